jacobi_result_reader: RTL and testbench

JACOBI_RESULT_READER -- requirements
Module: jacobi_result_reader

---
 rtl/jacobi_result_reader.sv | 142 ++++++++++++++
 tb/tb_jacobi_result_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_result_reader.sv
// rtl/jacobi_result_reader.sv - frame buffer for Jacobi results with hold/readback and max-abs tracking
module jacobi_result_reader #(
   parameter int  DATA_W  = 32,
   parameter int  N_WORDS = 8,
   localparam int ADDR_W  = $clog2(N_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_dat_i,
   input  logic              in_vld_i,
   output logic              in_rdy_o,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_dat_o,
   output logic              rd_vld_o,
   output logic              frame_rdy_o,
   input  logic              release_i,
   output logic [15:0]       frame_cnt_o,
   output logic [DATA_W-1:0] max_abs_o
);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(N_WORDS - 1);
   localparam logic [ADDR_W:0]   N_WORDS_W = (ADDR_W + 1)'(N_WORDS);
   localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W - 1){1'b0}}};
   localparam logic [DATA_W-1:0] MAX_POS   = {1'b0, {(DATA_W - 1){1'b1}}};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0]   mem_q [N_WORDS];
   logic [DATA_W-1:0]   mem_d [N_WORDS];
   logic [DATA_W-1:0]   run_max_q, run_max_d;
   logic [DATA_W-1:0]   max_abs_q, max_abs_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [DATA_W-1:0]   rd_dat_q, rd_dat_d;
   logic                rd_vld_q, rd_vld_d;

   logic [DATA_W-1:0]   in_abs;
   logic [DATA_W-1:0]   new_max;
   logic                xfer;
   logic                last_xfer;
   logic                rd_ok;

   assign xfer      = in_vld_i && (state_q == COLLECT);
   assign last_xfer = xfer && (wr_ptr_q == LAST_PTR);
   assign rd_ok     = rd_en_i && (state_q == HOLD) && ({1'b0, rd_addr_i} < N_WORDS_W);

   // Two's-complement magnitude; the most negative word has no positive twin, so it saturates.
   always_comb begin
      in_abs = in_dat_i;
      if (in_dat_i == MOST_NEG) begin
         in_abs = MAX_POS;
      end else if (in_dat_i[DATA_W-1]) begin
         in_abs = -in_dat_i;
      end
   end

   // Running maximum restarts at the first word of each frame and includes the current word.
   always_comb begin
      new_max = in_abs;
      if ((wr_ptr_q != '0) && (run_max_q > in_abs)) begin
         new_max = run_max_q;
      end
   end

   // Next-state logic: FSM, write pointer, frame statistics and registered readback.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      mem_d       = mem_q;
      run_max_d   = run_max_q;
      max_abs_d   = max_abs_q;
      frame_cnt_d = frame_cnt_q;
      rd_vld_d    = rd_ok;
      rd_dat_d    = rd_dat_q;

      if (rd_ok) begin
         rd_dat_d = mem_q[rd_addr_i];
      end

      case (state_q)
         COLLECT: begin
            if (xfer) begin
               mem_d[wr_ptr_q] = in_dat_i;
               run_max_d       = new_max;
               if (last_xfer) begin
                  wr_ptr_d    = '0;
                  max_abs_d   = new_max;
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  state_d     = HOLD;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (release_i) begin
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // Frame storage; contents only change on accepted words, so no reset is needed.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         wr_ptr_q    <= '0;
         run_max_q   <= '0;
         max_abs_q   <= '0;
         frame_cnt_q <= '0;
         rd_dat_q    <= '0;
         rd_vld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         run_max_q   <= run_max_d;
         max_abs_q   <= max_abs_d;
         frame_cnt_q <= frame_cnt_d;
         rd_dat_q    <= rd_dat_d;
         rd_vld_q    <= rd_vld_d;
      end
   end

   assign in_rdy_o    = (state_q == COLLECT);
   assign frame_rdy_o = (state_q == HOLD);
   assign rd_dat_o    = rd_dat_q;
   assign rd_vld_o    = rd_vld_q;
   assign frame_cnt_o = frame_cnt_q;
   assign max_abs_o   = max_abs_q;

endmodule

// File: tb/tb_jacobi_result_reader.sv
// tb/tb_jacobi_result_reader.sv - directed scoreboard bench for jacobi_result_reader
module tb_jacobi_result_reader;

   logic        clk;
   logic        rst;
   logic [31:0] in_dat_i;
   logic        in_vld_i;
   logic        in_rdy_o;
   logic        rd_en_i;
   logic [2:0]  rd_addr_i;
   logic [31:0] rd_dat_o;
   logic        rd_vld_o;
   logic        frame_rdy_o;
   logic        release_i;
   logic [15:0] frame_cnt_o;
   logic [31:0] max_abs_o;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [31:0] m_mem [8];
   int          m_ptr = 0;
   logic        m_hold = 1'b0;
   logic [31:0] m_run = '0;
   logic [31:0] m_max = '0;
   logic [15:0] m_cnt = '0;
   logic [31:0] m_last_rd = '0;
   logic [31:0] sb [$];

   jacobi_result_reader #(.DATA_W(32), .N_WORDS(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_dat_i    (in_dat_i),
      .in_vld_i    (in_vld_i),
      .in_rdy_o    (in_rdy_o),
      .rd_en_i     (rd_en_i),
      .rd_addr_i   (rd_addr_i),
      .rd_dat_o    (rd_dat_o),
      .rd_vld_o    (rd_vld_o),
      .frame_rdy_o (frame_rdy_o),
      .release_i   (release_i),
      .frame_cnt_o (frame_cnt_o),
      .max_abs_o   (max_abs_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] abs32(input logic [31:0] w);
      if (w == 32'h8000_0000) return 32'h7FFF_FFFF;
      if (w[31]) return 32'd0 - w;
      return w;
   endfunction

   // One clock: update the model from the driven inputs, clock, then compare outputs.
   task automatic step();
      logic        exp_vld;
      logic [31:0] a;
      logic [31:0] exp_rd;
      exp_vld = !rst && m_hold && rd_en_i;
      if (exp_vld) sb.push_back(m_mem[rd_addr_i]);
      if (rst) begin
         m_hold = 1'b0; m_ptr = 0; m_run = '0; m_max = '0; m_cnt = '0; m_last_rd = '0;
         sb.delete();
         exp_vld = 1'b0;
      end else if (!m_hold) begin
         if (in_vld_i) begin
            a = abs32(in_dat_i);
            m_mem[m_ptr] = in_dat_i;
            if (m_ptr == 0 || a > m_run) m_run = a;
            if (m_ptr == 7) begin
               m_hold = 1'b1; m_ptr = 0; m_max = m_run; m_cnt = m_cnt + 16'd1;
            end else begin
               m_ptr++;
            end
         end
      end else if (release_i) begin
         m_hold = 1'b0;
      end
      @(posedge clk);
      #1;
      check("rd_vld", {31'd0, rd_vld_o}, {31'd0, exp_vld});
      if (exp_vld) begin
         exp_rd = sb.pop_front();
         m_last_rd = exp_rd;
      end
      check("rd_dat", rd_dat_o, m_last_rd);
      check("in_rdy", {31'd0, in_rdy_o}, {31'd0, !m_hold});
      check("frame_rdy", {31'd0, frame_rdy_o}, {31'd0, m_hold});
      check("frame_cnt", {16'd0, frame_cnt_o}, {16'd0, m_cnt});
      check("max_abs", max_abs_o, m_max);
   endtask

   task automatic idle();
      in_vld_i = 1'b0; rd_en_i = 1'b0; release_i = 1'b0; rst = 1'b0;
   endtask

   task automatic send(input logic [31:0] w);
      in_vld_i = 1'b1; in_dat_i = w;
      step();
      in_vld_i = 1'b0;
   endtask

   task automatic read_all();
      for (int a = 0; a < 8; a++) begin
         rd_en_i = 1'b1; rd_addr_i = 3'(a);
         step();
      end
      rd_en_i = 1'b0;
   endtask

   task automatic release_frame();
      release_i = 1'b1;
      step();
      release_i = 1'b0;
   endtask

   int f1 [8] = '{1, -2, 3, -4, 5, -6, 7, -9};
   int f3 [8] = '{100, -50, 7, 0, 20, -300, 1, 2};

   initial begin
      in_dat_i = '0; rd_addr_i = '0;
      idle();

      // reset
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("reset_in_rdy", {31'd0, in_rdy_o}, 32'd1);
      check("reset_rd_dat", rd_dat_o, 32'd0);
      check("reset_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
      check("reset_max_abs", max_abs_o, 32'd0);
      step();

      // basic frame with valid held high
      in_vld_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_dat_i = f1[i];
         step();
         if (i == 6) check("pre_last_in_rdy", {31'd0, in_rdy_o}, 32'd1);
      end
      in_vld_i = 1'b0;
      check("basic_in_rdy_low", {31'd0, in_rdy_o}, 32'd0);
      check("basic_frame_rdy", {31'd0, frame_rdy_o}, 32'd1);
      check("basic_frame_cnt", {16'd0, frame_cnt_o}, 32'd1);
      check("basic_max_abs", max_abs_o, 32'd9);

      // readback of all words back-to-back
      read_all();
      check("readback_last", rd_dat_o, 32'hFFFF_FFF7);
      step();

      // backpressure while held
      in_vld_i = 1'b1; in_dat_i = 32'h55;
      for (int i = 0; i < 10; i++) step();
      in_vld_i = 1'b0;
      read_all();
      in_vld_i = 1'b1;
      release_frame();
      send(32'h55);
      for (int i = 1; i < 8; i++) send(32'(i + 1));
      check("bp_frame_cnt", {16'd0, frame_cnt_o}, 32'd2);
      check("bp_max_abs", max_abs_o, 32'h55);
      rd_en_i = 1'b1; rd_addr_i = 3'd0;
      step();
      rd_en_i = 1'b0;
      check("bp_addr0", rd_dat_o, 32'h55);
      release_frame();

      // gaps in valid and saturation of the most negative word
      for (int k = 0; k < 16; k++) begin
         if (k % 2 == 1) begin
            in_vld_i = 1'b1;
            in_dat_i = (k / 2 == 3) ? 32'h8000_0000 : f3[k / 2];
         end else begin
            in_vld_i = 1'b0;
         end
         step();
         if (k == 14) check("gap_not_done", {31'd0, frame_rdy_o}, 32'd0);
      end
      in_vld_i = 1'b0;
      check("gap_frame_rdy", {31'd0, frame_rdy_o}, 32'd1);
      check("gap_frame_cnt", {16'd0, frame_cnt_o}, 32'd3);
      check("gap_max_abs", max_abs_o, 32'h7FFF_FFFF);
      read_all();
      release_frame();

      // reset in the middle of a frame
      for (int i = 0; i < 5; i++) send(32'(1000 + i));
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) send(32'(10 + i));
      check("mid_rst_frame_cnt", {16'd0, frame_cnt_o}, 32'd1);
      check("mid_rst_max_abs", max_abs_o, 32'd17);
      rd_en_i = 1'b1; rd_addr_i = 3'd0;
      step();
      check("mid_rst_addr0", rd_dat_o, 32'd10);

      // read and release in the same cycle
      rd_addr_i = 3'd2; release_i = 1'b1;
      step();
      release_i = 1'b0;
      check("simul_rd_vld", {31'd0, rd_vld_o}, 32'd1);
      check("simul_rd_dat", rd_dat_o, 32'd12);
      check("simul_frame_rdy", {31'd0, frame_rdy_o}, 32'd0);
      check("simul_in_rdy", {31'd0, in_rdy_o}, 32'd1);

      // read request while collecting is ignored, data holds
      rd_addr_i = 3'd5;
      step();
      release_i = 1'b1;
      step();
      idle();
      check("collect_rd_hold", rd_dat_o, 32'd12);
      check("collect_release_ignored", {31'd0, in_rdy_o}, 32'd1);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
